// File: rtl/seq_multdiv_fault.sv
// Sequential signed multiplier (radix-4 Booth) and divider (restoring) with a
// single-bit fault-injection hook on the result register.
module seq_multdiv_fault #(
    parameter int WIDTH     = 32,
    parameter int FAULT_BIT = 7
) (
    input  logic                    clock,
    input  logic                    aclr_n,
    input  logic signed [WIDTH-1:0] data_operandA,
    input  logic signed [WIDTH-1:0] data_operandB,
    input  logic                    ctrl_MULT,
    input  logic                    ctrl_DIV,
    input  logic                    ctrl_flip,
    output logic        [WIDTH-1:0] data_result,
    output logic                    data_exception,
    output logic                    data_resultRDY,
    output logic                    busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    MULT_LAST = CW'(WIDTH/2 - 1);
    localparam logic [CW-1:0]    DIV_LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] FLIP_BIT  = {{(WIDTH-1){1'b0}}, 1'b1} << FAULT_BIT;

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2*WIDTH:0]        acc_q, acc_d;
    logic [WIDTH-1:0]        rem_q, rem_d;
    logic [WIDTH-1:0]        quo_q, quo_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        result_q, result_d;
    logic                    exc_q, exc_d;

    logic                    start_mult, start_div, mult_last, div_last;
    logic [WIDTH-1:0]        flip_mask, opa_mag, b_mag;
    logic signed [WIDTH+1:0] a_ext, hi_ext, pp, booth_sum;
    logic [2*WIDTH:0]        acc_step;
    logic [2*WIDTH-1:0]      prod;
    logic [WIDTH:0]          trial;
    logic [WIDTH-1:0]        rem_step, quo_step, div_res, mult_res;
    logic                    mult_exc, div_exc;

    assign start_mult = ctrl_MULT & ~ctrl_DIV;
    assign start_div  = ctrl_DIV & ~ctrl_MULT;
    assign mult_last  = (cnt_q == MULT_LAST);
    assign div_last   = (cnt_q == DIV_LAST);
    assign flip_mask  = ctrl_flip ? FLIP_BIT : '0;
    assign opa_mag    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag      = b_q[WIDTH-1] ? -b_q : b_q;

    // Booth step: the add is done two bits wider so +/-2A never overflows;
    // after the shift by 2 the upper part fits back into WIDTH bits.
    always_comb begin
        a_ext  = {{2{a_q[WIDTH-1]}}, a_q};
        hi_ext = {{2{acc_q[2*WIDTH]}}, acc_q[2*WIDTH:WIDTH+1]};
        case (acc_q[2:0])
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext <<< 1;
            3'b100:         pp = -(a_ext <<< 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
        booth_sum = hi_ext + pp;
        acc_step  = {booth_sum[WIDTH+1:2], booth_sum[1:0], acc_q[WIDTH:2]};
        prod      = acc_step[2*WIDTH:1];
        mult_res  = prod[WIDTH-1:0];
        mult_exc  = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
    end

    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_mag};
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
        // MIN / -1 falls out naturally: magnitude 2^(W-1), same signs, no negation.
        div_exc = (b_q == '0) || ((a_q == MIN_VAL) && (b_q == {WIDTH{1'b1}}));
        if (b_q == '0)
            div_res = '0;
        else if (a_q[WIDTH-1] ^ b_q[WIDTH-1])
            div_res = -quo_step;
        else
            div_res = quo_step;
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_mult)     state_d = MULT;
                else if (start_div) state_d = DIV;
            end
            MULT:    if (mult_last) state_d = DONE;
            DIV:     if (div_last)  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            IDLE: begin
                if (start_mult) begin
                    a_d   = data_operandA;
                    b_d   = data_operandB;
                    cnt_d = '0;
                    acc_d = {{WIDTH{1'b0}}, data_operandB, 1'b0};
                end else if (start_div) begin
                    a_d   = data_operandA;
                    b_d   = data_operandB;
                    cnt_d = '0;
                    rem_d = '0;
                    quo_d = opa_mag;
                end
            end
            MULT: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (mult_last) begin
                    result_d = mult_res ^ flip_mask;
                    exc_d    = mult_exc;
                end
            end
            DIV: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (div_last) begin
                    result_d = div_res ^ flip_mask;
                    exc_d    = div_exc;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy           = (state_q == MULT) || (state_q == DIV);
        data_resultRDY = (state_q == DONE);
        data_result    = result_q;
        data_exception = exc_q;
    end

endmodule

// File: tb/tb_seq_multdiv_fault.sv
// Bench for seq_multdiv_fault: vector table plus random model vectors,
// scoreboard queue, and hand sequences for control and reset corners.
module tb_seq_multdiv_fault;

    logic               clock = 1'b0;
    logic               aclr_n;
    logic signed [31:0] data_operandA, data_operandB;
    logic               ctrl_MULT, ctrl_DIV, ctrl_flip;
    logic        [31:0] data_result;
    logic               data_exception, data_resultRDY, busy;

    seq_multdiv_fault #(.WIDTH(32), .FAULT_BIT(7)) dut (
        .clock          (clock),
        .aclr_n         (aclr_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .ctrl_flip      (ctrl_flip),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        bit          flip;
        logic [31:0] res;
        bit          exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        bit          exc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[14];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input bit is_div, input logic signed [31:0] a,
                                   input logic signed [31:0] b, input bit flip);
        exp_t e;
        logic signed [63:0] p;
        if (!is_div) begin
            p     = a * b;
            e.res = p[31:0];
            e.exc = (p[63:32] != {32{p[31]}});
            e.lat = 17;
        end else begin
            if (b == 0) begin
                e.res = 32'h0;
                e.exc = 1'b1;
            end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
                e.res = 32'h8000_0000;
                e.exc = 1'b1;
            end else begin
                e.res = a / b;
                e.exc = 1'b0;
            end
            e.lat = 33;
        end
        if (flip) e.res[7] = ~e.res[7];
        return e;
    endfunction

    // Start at a negedge, scramble operands and flip while busy, assert the
    // requested flip only in the cycle before the finishing edge.
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input bit flip, input logic [31:0] res, input bit exc);
        exp_t e;
        int   edges, busy_cnt;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = !is_div;
        ctrl_DIV      = is_div;
        ctrl_flip     = !flip;
        sb.push_back('{res: res, exc: exc, lat: (is_div ? 33 : 17)});
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = ~a;
        data_operandB = ~b;
        edges         = 1;
        busy_cnt      = 0;
        e             = sb.pop_front();
        while (!data_resultRDY && edges < 100) begin
            if (busy) busy_cnt++;
            ctrl_flip = (edges == e.lat - 1) ? flip : !flip;
            @(negedge clock);
            edges++;
        end
        chk("latency", 64'(edges), 64'(e.lat));
        chk("busy_cycles", 64'(busy_cnt), 64'(e.lat - 1));
        chk("busy_in_done", 64'(busy), 64'd0);
        chk("result", 64'(data_result), 64'(e.res));
        chk("exception", 64'(data_exception), 64'(e.exc));
        ctrl_flip = !flip;
        @(negedge clock);
        chk("rdy_pulse_end", 64'(data_resultRDY), 64'd0);
        chk("result_hold", 64'(data_result), 64'(e.res));
        ctrl_flip = 1'b0;
    endtask

    initial begin
        exp_t m;
        int   edges, rdy_seen;
        logic [31:0] ra, rb;
        bit   rd, rf;

        tbl[0]  = '{0, 32'd7,          -32'sd3,       0, 32'hFFFF_FFEB, 0};
        tbl[1]  = '{0, 32'd7,          -32'sd3,       1, 32'hFFFF_FF6B, 0};
        tbl[2]  = '{1, -32'sd21,       32'd4,         0, 32'hFFFF_FFFB, 0};
        tbl[3]  = '{1, 32'd5,          32'd0,         0, 32'h0000_0000, 1};
        tbl[4]  = '{0, 32'h0001_0000,  32'h0001_0000, 0, 32'h0000_0000, 1};
        tbl[5]  = '{1, 32'h8000_0000,  32'hFFFF_FFFF, 0, 32'h8000_0000, 1};
        tbl[6]  = '{0, 32'h8000_0000,  32'hFFFF_FFFF, 0, 32'h8000_0000, 1};
        tbl[7]  = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 32'h0000_0001, 0};
        tbl[8]  = '{1, 32'd7,          -32'sd2,       0, 32'hFFFF_FFFD, 0};
        tbl[9]  = '{1, -32'sd7,        -32'sd2,       0, 32'h0000_0003, 0};
        tbl[10] = '{1, 32'd100,        32'd7,         1, 32'h0000_008E, 0};
        tbl[11] = '{0, 32'h7FFF_FFFF,  32'd2,         0, 32'hFFFF_FFFE, 1};
        tbl[12] = '{1, 32'h8000_0000,  32'd0,         1, 32'h0000_0080, 1};
        tbl[13] = '{0, 32'h8000_0000,  32'h8000_0000, 0, 32'h0000_0000, 1};

        aclr_n = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        ctrl_flip = 1'b0;
        #1;
        chk("reset_result", 64'(data_result), 64'd0);
        chk("reset_exc", 64'(data_exception), 64'd0);
        chk("reset_rdy", 64'(data_resultRDY), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clock);
        aclr_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_op(tbl[i].is_div, tbl[i].a, tbl[i].b, tbl[i].flip, tbl[i].res, tbl[i].exc);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom;
            if (i % 2 == 0) ra = ra >>> 8;
            rd = (i % 3 != 0);
            rf = ($urandom_range(0, 3) == 0);
            m  = model(rd, ra, rb, rf);
            run_op(rd, ra, rb, rf, m.res, m.exc);
        end

        // ctrl_MULT held through a divide: divide unaffected, then a multiply
        // of the operands present at that IDLE cycle starts.
        @(negedge clock);
        data_operandA = -32'sd21;
        data_operandB = 32'sd4;
        ctrl_DIV = 1'b1;
        sb.push_back(model(1, -32'sd21, 32'sd4, 0));
        @(negedge clock);
        ctrl_DIV  = 1'b0;
        ctrl_MULT = 1'b1;
        data_operandA = 32'sd3;
        data_operandB = 32'sd5;
        edges = 1;
        while (!data_resultRDY && edges < 100) begin
            @(negedge clock);
            edges++;
        end
        m = sb.pop_front();
        chk("hold_div_latency", 64'(edges), 64'd33);
        chk("hold_div_result", 64'(data_result), 64'(m.res));
        chk("hold_div_exc", 64'(data_exception), 64'(m.exc));
        sb.push_back(model(0, 32'sd3, 32'sd5, 0));
        @(negedge clock);
        chk("hold_idle_busy", 64'(busy), 64'd0);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        chk("hold_second_busy", 64'(busy), 64'd1);
        edges = 1;
        while (!data_resultRDY && edges < 100) begin
            @(negedge clock);
            edges++;
        end
        m = sb.pop_front();
        chk("hold_mult_latency", 64'(edges), 64'd17);
        chk("hold_mult_result", 64'(data_result), 64'(m.res));

        // Both requests together never start anything.
        @(negedge clock);
        ctrl_MULT = 1'b1;
        ctrl_DIV  = 1'b1;
        rdy_seen  = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (busy || data_resultRDY) rdy_seen++;
        end
        chk("both_no_start", 64'(rdy_seen), 64'd0);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;

        // Asynchronous reset in the middle of a multiply.
        @(negedge clock);
        data_operandA = 32'sd7;
        data_operandB = -32'sd3;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (4) @(negedge clock);
        chk("pre_abort_busy", 64'(busy), 64'd1);
        #2;
        aclr_n = 1'b0;
        #1;
        chk("abort_result", 64'(data_result), 64'd0);
        chk("abort_exc", 64'(data_exception), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        aclr_n = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (data_resultRDY || busy) rdy_seen++;
        end
        chk("abort_no_rdy", 64'(rdy_seen), 64'd0);

        run_op(0, 32'd7, -32'sd3, 0, 32'hFFFF_FFEB, 0);
        run_op(1, -32'sd21, 32'd4, 0, 32'hFFFF_FFFB, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
